// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU with branch compare; RV32M multiply and iterative
// radix-2 divide are built only when RV32M_EN is defined.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  input  logic [3:0]            ALUctrl,
  input  logic                  mul_sel,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ,
  output logic                  div_ready
);
  localparam int W = DATA_WIDTH;

  logic [W-1:0] alu_res;
  logic [4:0]   shamt;
  assign shamt = ALUop2[4:0];

  always_comb begin
    case (ALUctrl)
      4'b1000: alu_res = ALUop1 - ALUop2;
      4'b0001: alu_res = ALUop1 << shamt;
      4'b0101: alu_res = ALUop1 >> shamt;
      4'b1101: alu_res = $signed(ALUop1) >>> shamt;
      4'b0010: alu_res = {{(W-1){1'b0}}, $signed(ALUop1) < $signed(ALUop2)};
      4'b0011: alu_res = {{(W-1){1'b0}}, ALUop1 < ALUop2};
      4'b0100: alu_res = ALUop1 ^ ALUop2;
      4'b0110: alu_res = ALUop1 | ALUop2;
      4'b0111: alu_res = ALUop1 & ALUop2;
      default: alu_res = ALUop1 + ALUop2;
    endcase
  end

  // Branch condition follows funct3 regardless of mul_sel.
  always_comb begin
    case (ALUctrl[2:0])
      3'b000:  EQ = ALUop1 == ALUop2;
      3'b001:  EQ = ALUop1 != ALUop2;
      3'b100:  EQ = $signed(ALUop1) < $signed(ALUop2);
      3'b101:  EQ = $signed(ALUop1) >= $signed(ALUop2);
      3'b110:  EQ = ALUop1 < ALUop2;
      3'b111:  EQ = ALUop1 >= ALUop2;
      default: EQ = 1'b0;
    endcase
  end

`ifdef RV32M_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam int PW = 2 * W + 2;

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  lat_a, lat_b, dvs, quo, rem;
  logic [1:0]    lat_op;
  logic          div_req, match, div_hit, sgn_in, sgn_lat;
  logic [W:0]    shl, diff;
  logic [W-1:0]  a_mag, b_mag, q_fix, r_fix, div_res, mul_res;
  logic signed [W:0]    ma, mb;
  logic signed [PW-1:0] prod;
  logic          unused_prod;

  // One 33x33 signed multiplier covers all four variants via the extension bit.
  assign ma      = {(ALUctrl[1:0] != 2'b11) & ALUop1[W-1], ALUop1};
  assign mb      = {~ALUctrl[1] & ALUop2[W-1], ALUop2};
  assign prod    = PW'(ma) * PW'(mb);
  assign mul_res = (ALUctrl[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
  assign unused_prod = &{1'b0, prod[PW-1:2*W]};

  assign div_req = mul_sel & ALUctrl[2];
  assign match   = div_req && ALUop1 == lat_a && ALUop2 == lat_b && ALUctrl[1:0] == lat_op;
  assign div_hit = (state == DONE) && match;

  assign sgn_in = ~ALUctrl[0];
  assign a_mag  = (sgn_in & ALUop1[W-1]) ? -ALUop1 : ALUop1;
  assign b_mag  = (sgn_in & ALUop2[W-1]) ? -ALUop2 : ALUop2;

  // Restoring step: no borrow means the shifted remainder covers the divisor.
  assign shl  = {rem, quo[W-1]};
  assign diff = shl - {1'b0, dvs};

  assign sgn_lat = ~lat_op[0];
  assign q_fix   = (lat_b == '0) ? '1 :
                   (sgn_lat & (lat_a[W-1] ^ lat_b[W-1])) ? -quo : quo;
  assign r_fix   = (lat_b == '0) ? lat_a : (sgn_lat & lat_a[W-1]) ? -rem : rem;
  assign div_res = lat_op[1] ? r_fix : q_fix;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (div_req) state_nxt = BUSY;
      BUSY:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (!match) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= '0;
      dvs    <= '0;
      quo    <= '0;
      rem    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && div_req) begin
        lat_a  <= ALUop1;
        lat_b  <= ALUop2;
        lat_op <= ALUctrl[1:0];
        dvs    <= b_mag;
        quo    <= a_mag;
        rem    <= '0;
        cnt    <= CW'(DIV_CYCLES);
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
        if (!diff[W]) begin
          rem <= diff[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= shl[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    ALUout    = alu_res;
    div_ready = 1'b1;
    if (mul_sel) begin
      if (!ALUctrl[2]) begin
        ALUout = mul_res;
      end else begin
        ALUout    = div_hit ? div_res : '0;
        div_ready = div_hit;
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst, mul_sel};
  assign ALUout    = alu_res;
  assign div_ready = 1'b1;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expectations, a negedge
// monitor pops them whenever div_ready shows a result.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUop1, ALUop2, ALUout;
  logic [3:0]  ALUctrl;
  logic        mul_sel, EQ, div_ready;

`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] out;
    logic        eq;
    int          lat;
    int          t0;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int checks = 0, passes = 0, cyc = 0;

  alu_exec_unit #(.DATA_WIDTH(32), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .mul_sel(mul_sel), .ALUout(ALUout), .EQ(EQ), .div_ready(div_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Reference model: plain arithmetic on the ISA definitions.
  function automatic logic [31:0] ref_out(input logic [31:0] a, b, input logic [3:0] c, input logic m);
    longint x, y;
    logic [63:0] p;
    x = longint'($signed(a));
    y = longint'($signed(b));
    if (m && M_EN) begin
      case (c[2:0])
        3'd0: begin p = x * y; return p[31:0]; end
        3'd1: begin p = x * y; return p[63:32]; end
        3'd2: begin p = x * longint'({32'h0, b}); return p[63:32]; end
        3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
        3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(x / y);
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: return (b == 0) ? a : 32'(x % y);
        default: return (b == 0) ? a : a % b;
      endcase
    end
    case (c)
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b1101: return 32'(x >>> b[4:0]);
      4'b0010: return (x < y) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic ref_eq(input logic [31:0] a, b, input logic [3:0] c);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (c[2:0])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return x < y;
      3'd5: return x >= y;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t it;
    if (!rst && sb.size() > 0) begin
      if (div_ready) begin
        it = sb.pop_front();
        chk({it.nm, ".out"}, ALUout, it.out);
        chk({it.nm, ".eq"}, 32'(EQ), 32'(it.eq));
        if (it.lat >= 0) chk({it.nm, ".lat"}, 32'(cyc - it.t0), 32'(it.lat));
      end else if (sb[0].lat > 0) begin
        chk({sb[0].nm, ".busy_out"}, ALUout, 32'h0);
      end
    end
  end

  task automatic drain(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sb.size() == 0) return;
    end
    checks++;
    $display("FAIL %s.timeout: no result within 200 cycles, required one", nm);
    sb.delete();
  endtask

  task automatic issue(input logic [31:0] a, b, input logic [3:0] c, input logic m,
                       input logic [31:0] e_out, input logic e_eq, input int lat, input string nm);
    exp_t it;
    @(posedge clk); #1;
    ALUop1 = a; ALUop2 = b; ALUctrl = c; mul_sel = m;
    it.out = e_out; it.eq = e_eq; it.lat = lat; it.t0 = cyc; it.nm = nm;
    sb.push_back(it);
    drain(nm);
  endtask

  task automatic filler();
    issue(32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 0, "filler");
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  c;
    logic        m, dv;
    rst = 1'b1; ALUop1 = '0; ALUop2 = '0; ALUctrl = '0; mul_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(div_ready), 32'd1);
    chk("rst.out", ALUout, 32'h0);

    issue(32'h5, 32'hFFFF_FFFD, 4'b0000, 1'b0, 32'h2, 1'b0, 0, "add");
    issue(32'h3, 32'h5, 4'b1000, 1'b0, 32'hFFFF_FFFE, 1'b0, 0, "sub");
    issue(32'h8000_0000, 32'h4, 4'b1101, 1'b0, 32'hF800_0000, 1'b0, 0, "sra");
    issue(32'h8000_0000, 32'h4, 4'b0101, 1'b0, 32'h0800_0000, 1'b0, 0, "srl");
    issue(32'hFFFF_FFFF, 32'h1, 4'b0010, 1'b0, 32'h1, 1'b0, 0, "slt");
    issue(32'hFFFF_FFFF, 32'h1, 4'b0011, 1'b0, 32'h0, 1'b0, 0, "sltu");
    issue(32'hFFFF_FFFF, 32'h1, 4'b0100, 1'b0, 32'hFFFF_FFFE, 1'b1, 0, "blt");
    issue(32'hFFFF_FFFF, 32'h1, 4'b0110, 1'b0, 32'hFFFF_FFFF, 1'b0, 0, "bltu");
    issue(32'h7, 32'h7, 4'b0000, 1'b0, 32'hE, 1'b1, 0, "beq");

    if (M_EN) begin
      issue(32'h8000_0000, 32'h8000_0000, 4'b0001, 1'b1, 32'h4000_0000, 1'b0, 0, "mulh");
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0011, 1'b1, 32'hFFFF_FFFE, 1'b0, 0, "mulhu");
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 1'b1, 32'h1, 1'b1, 0, "mul");
      issue(32'hFFFF_FFF9, 32'h2, 4'b0100, 1'b1, 32'hFFFF_FFFD, 1'b1, 33, "div");
      filler();
      issue(32'hFFFF_FFF9, 32'h2, 4'b0110, 1'b1, 32'hFFFF_FFFF, 1'b0, 33, "rem");
      filler();
      issue(32'h1234, 32'h0, 4'b0101, 1'b1, 32'hFFFF_FFFF, 1'b1, 33, "divu0");
      filler();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 4'b0110, 1'b1, 32'h0, 1'b1, 33, "rem_ovf");
      filler();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 4'b0100, 1'b1, 32'h8000_0000, 1'b1, 33, "div_ovf");
      filler();
      // Back-to-back: each new request first passes DONE->IDLE, one extra cycle.
      issue(32'd100, 32'd7, 4'b0100, 1'b1, 32'd14, 1'b0, 33, "b2b0");
      issue(32'hFFFF_FF9C, 32'd7, 4'b0100, 1'b1, 32'hFFFF_FFF2, 1'b1, 34, "b2b1");
      issue(32'd100, 32'd7, 4'b0111, 1'b1, 32'd2, 1'b1, 34, "b2b2");
      filler();

      begin : rst_abort
        exp_t it;
        @(posedge clk); #1;
        ALUop1 = 32'hFFFF_FFF9; ALUop2 = 32'h2; ALUctrl = 4'b0100; mul_sel = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        it.out = 32'hFFFF_FFFD; it.eq = 1'b1; it.lat = 33; it.t0 = cyc; it.nm = "rst_div";
        sb.push_back(it);
        @(negedge clk);
        chk("rst_div.ready_low", 32'(div_ready), 32'd0);
        drain("rst_div");
      end
      filler();
    end else begin
      issue(32'h5, 32'hFFFF_FFFD, 4'b0000, 1'b1, 32'h2, 1'b0, 0, "nom_add");
      issue(32'hFFFF_FFF9, 32'h2, 4'b0100, 1'b1, 32'hFFFF_FFFB, 1'b1, 0, "nom_xor");
    end

    for (int k = 0; k < 80; k++) begin
      a  = pick();
      b  = pick();
      c  = 4'($urandom);
      m  = ($urandom_range(0, 2) == 0);
      dv = M_EN && m && c[2];
      issue(a, b, c, m, ref_out(a, b, c, m), ref_eq(a, b, c), dv ? 33 : 0, "rnd");
      if (dv) filler();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
